// File: rtl/mem_if_pkg.sv
// Shared definitions for the LSU-to-data-memory stall handshake.
package mem_if_pkg;

  // RISC-V load funct3 values
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store funct3 values
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Memory sign_mask encodings: bit 3 = sign-extend, bits 2:0 = byte lanes
  localparam logic [3:0] SM_BYTE_S = 4'b1001;
  localparam logic [3:0] SM_HALF_S = 4'b1011;
  localparam logic [3:0] SM_WORD   = 4'b0111;
  localparam logic [3:0] SM_BYTE_U = 4'b0001;
  localparam logic [3:0] SM_HALF_U = 4'b0011;

  // Response error codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_req_decode.sv
// Combinational funct3/address decode into the memory sign_mask plus error flags.
module mem_req_decode
  import mem_if_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_is_store,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_sign_mask,
  output logic       o_illegal,
  output logic       o_misaligned
);

  // Map funct3 to a sign_mask; alignment is only judged for legal encodings so illegal wins
  always_comb begin
    o_sign_mask  = 4'b0000;
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    if (i_is_store) begin
      case (i_funct3)
        F3_SB:   o_sign_mask = SM_BYTE_U;
        F3_SH:   o_sign_mask = SM_HALF_U;
        F3_SW:   o_sign_mask = SM_WORD;
        default: o_illegal   = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_LB:   o_sign_mask = SM_BYTE_S;
        F3_LH:   o_sign_mask = SM_HALF_S;
        F3_LW:   o_sign_mask = SM_WORD;
        F3_LBU:  o_sign_mask = SM_BYTE_U;
        F3_LHU:  o_sign_mask = SM_HALF_U;
        default: o_illegal   = 1'b1;
      endcase
    end
    if (!o_illegal) begin
      if (i_funct3[1:0] == 2'b01) begin
        o_misaligned = i_addr_lo[0];
      end else if (i_funct3[1:0] == 2'b10) begin
        o_misaligned = |i_addr_lo;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, single-cycle memory strobe,
// tracks clk_stall rise and fall, returns load data or an error response.
//
//   state   | meaning
//   IDLE    | ready for a request; errors short-circuit to RESP
//   REQ     | memread/memwrite strobe high for this single cycle
//   WAIT_HI | waiting for the memory to raise clk_stall
//   WAIT_LO | waiting for clk_stall to fall, then capture read data
//   RESP    | rsp_valid pulse, back to IDLE
module lsu_mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int unsigned   CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_is_store, w_is_store_nxt;
  logic          r_req_ready, w_req_ready_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]    r_rsp_err, w_rsp_err_nxt;
  logic [31:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic          r_memread, w_memread_nxt;
  logic          r_memwrite, w_memwrite_nxt;
  logic [3:0]    r_sign_mask, w_sign_mask_nxt;

  logic [3:0]    w_dec_mask;
  logic          w_dec_illegal;
  logic          w_dec_misaligned;

  mem_req_decode u_decode (
    .i_funct3     (req_funct3),
    .i_is_store   (req_is_store),
    .i_addr_lo    (req_addr[1:0]),
    .o_sign_mask  (w_dec_mask),
    .o_illegal    (w_dec_illegal),
    .o_misaligned (w_dec_misaligned)
  );

  // Saturating wait counter so it can never wrap back under the limit
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Next-state and next-output logic; all outputs leave through registers
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_is_store_nxt  = r_is_store;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_memread_nxt   = 1'b0;
    w_memwrite_nxt  = 1'b0;
    w_sign_mask_nxt = r_sign_mask;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_req_ready_nxt = 1'b0;
          w_is_store_nxt  = req_is_store;
          if (w_dec_illegal || w_dec_misaligned) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = 32'h0;
            w_rsp_err_nxt   = w_dec_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            w_state_nxt     = ST_RESP;
          end else begin
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_wdata;
            w_sign_mask_nxt = w_dec_mask;
            w_memread_nxt   = !req_is_store;
            w_memwrite_nxt  = req_is_store;
            w_cnt_nxt       = '0;
            w_state_nxt     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI, ST_WAIT_LO: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_state == ST_WAIT_HI && mem_clk_stall) begin
          w_state_nxt = ST_WAIT_LO;
        end else if (r_state == ST_WAIT_LO && !mem_clk_stall) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_is_store ? 32'h0 : mem_read_data;
          w_rsp_err_nxt   = ERR_OK;
          w_state_nxt     = ST_RESP;
        end else if (w_cnt_inc == CNT_MAX) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = 32'h0;
          w_rsp_err_nxt   = ERR_TIMEOUT;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
      default: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_is_store  <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= ERR_OK;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_sign_mask <= 4'b0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_is_store  <= w_is_store_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_memread   <= w_memread_nxt;
      r_memwrite  <= w_memwrite_nxt;
      r_sign_mask <= w_sign_mask_nxt;
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign mem_memread    = r_memread;
  assign mem_memwrite   = r_memwrite;
  assign mem_sign_mask  = r_sign_mask;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator with a behavioural stalling data memory.
module tb_lsu_mem_initiator;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_clk_stall = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_rsp = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] strb_addr = 32'h0;
  logic [31:0] strb_wdata = 32'h0;
  logic [3:0]  strb_mask = 4'h0;

  // Memory model: strobe seen -> stall for two cycles, then drop stall with read data
  logic [7:0]  mem_b [0:16383];
  bit          model_en = 1'b1;
  int          mm_cnt = 0;
  logic [31:0] mm_addr = 32'h0;
  logic [3:0]  mm_mask = 4'h0;
  logic        mm_rd = 1'b0;

  function automatic logic [31:0] mm_load(input logic [31:0] a, input logic [3:0] m);
    logic [13:0] i;
    logic [31:0] v;
    i = a[13:0];
    case (m[2:0])
      3'b001:  v = {{24{m[3] & mem_b[i][7]}}, mem_b[i]};
      3'b011:  v = {{16{m[3] & mem_b[i+14'd1][7]}}, mem_b[i+14'd1], mem_b[i]};
      default: v = {mem_b[i+14'd3], mem_b[i+14'd2], mem_b[i+14'd1], mem_b[i]};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (mm_cnt == 0) begin
      if (model_en && (mem_memread || mem_memwrite)) begin
        mem_clk_stall <= 1'b1;
        mm_cnt  <= 1;
        mm_addr <= mem_addr;
        mm_mask <= mem_sign_mask;
        mm_rd   <= mem_memread;
        if (mem_memwrite) begin
          mem_b[mem_addr[13:0]] = mem_write_data[7:0];
          if (mem_sign_mask[1]) mem_b[mem_addr[13:0]+14'd1] = mem_write_data[15:8];
          if (mem_sign_mask[2]) begin
            mem_b[mem_addr[13:0]+14'd2] = mem_write_data[23:16];
            mem_b[mem_addr[13:0]+14'd3] = mem_write_data[31:24];
          end
        end
      end
    end else if (mm_cnt == 1) begin
      mm_cnt <= 2;
    end else begin
      mem_clk_stall <= 1'b0;
      mm_cnt <= 0;
      if (mm_rd) mem_read_data <= mm_load(mm_addr, mm_mask);
    end
  end

  // Monitor: strobe counting and scoreboard pop on each response
  always @(negedge clk) begin
    if (mem_memread) n_rd++;
    if (mem_memwrite) n_wr++;
    if (mem_memread || mem_memwrite) begin
      strb_addr  = mem_addr;
      strb_wdata = mem_write_data;
      strb_mask  = mem_sign_mask;
    end
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected_rsp got rdata=%h err=%b exp no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata) begin
          n_errors++;
          $display("FAIL sb_rdata got %h exp %h", rsp_rdata, e.rdata);
        end
        n_checks++;
        if (rsp_err !== e.err) begin
          n_errors++;
          $display("FAIL sb_err got %b exp %b", rsp_err, e.err);
        end
        n_checks++;
        if ((cyc - acc_cyc) != e.lat) begin
          n_errors++;
          $display("FAIL sb_latency got %0d exp %0d", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  // One request through the unit with expected response and strobe behaviour
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic [1:0] ee,
                        input int el, input int erd, input int ewr, input logic [3:0] emask);
    exp_t e;
    int   base;
    int   k;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_idle got %b exp 1", req_ready);
    end
    n_rd = 0;
    n_wr = 0;
    base = n_rsp;
    e.rdata = er;
    e.err   = ee;
    e.lat   = el;
    sb_q.push_back(e);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_after_accept got %b exp 0", req_ready);
    end
    k = 0;
    while (n_rsp == base && k < 40) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (n_rsp == base) begin
      n_errors++;
      $display("FAIL rsp_timeout got no response exp response within 40 cycles");
      sb_q.delete();
    end
    n_checks++;
    if (n_rd != erd || n_wr != ewr) begin
      n_errors++;
      $display("FAIL strobe_count got rd=%0d wr=%0d exp rd=%0d wr=%0d", n_rd, n_wr, erd, ewr);
    end
    if (erd + ewr > 0) begin
      n_checks++;
      if (strb_mask !== emask || strb_addr !== a) begin
        n_errors++;
        $display("FAIL strobe_mask_addr got mask=%b addr=%h exp mask=%b addr=%h",
                 strb_mask, strb_addr, emask, a);
      end
    end
    if (ewr > 0) begin
      n_checks++;
      if (strb_wdata !== wd) begin
        n_errors++;
        $display("FAIL strobe_wdata got %h exp %h", strb_wdata, wd);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_data,
         mem_memread, mem_memwrite, mem_sign_mask} !==
        {1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0}) begin
      n_errors++;
      $display("FAIL %s got ready=%b vld=%b rdata=%h err=%b addr=%h wd=%h rd=%b wr=%b mask=%b exp idle zeros",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write_data,
               mem_memread, mem_memwrite, mem_sign_mask);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    check_reset_vals("reset_values");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    mem_b[14'h40] = 8'hEF;
    mem_b[14'h41] = 8'hBE;
    mem_b[14'h42] = 8'hAD;
    mem_b[14'h43] = 8'hDE;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 2'b00, 4, 1, 0, 4'b0111);
  endtask

  task automatic test_lb_lbu();
    mem_b[14'h41] = 8'h80;
    do_req(1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFF80, 2'b00, 4, 1, 0, 4'b1001);
    do_req(1'b0, 3'b100, 32'h41, 32'h0, 32'h00000080, 2'b00, 4, 1, 0, 4'b0001);
  endtask

  task automatic test_sh();
    do_req(1'b1, 3'b001, 32'h2002, 32'h00001234, 32'h0, 2'b00, 4, 0, 1, 4'b0011);
    do_req(1'b0, 3'b001, 32'h2002, 32'h0, 32'h00001234, 2'b00, 4, 1, 0, 4'b1011);
    do_req(1'b1, 3'b010, 32'h2004, 32'hCAFEF00D, 32'h0, 2'b00, 4, 0, 1, 4'b0111);
    do_req(1'b0, 3'b101, 32'h2006, 32'h0, 32'h0000CAFE, 2'b00, 4, 1, 0, 4'b0011);
  endtask

  task automatic test_decode_err();
    do_req(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 2'b01, 0, 0, 0, 4'h0);
    do_req(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 2'b10, 0, 0, 0, 4'h0);
    do_req(1'b0, 3'b011, 32'h43, 32'h0, 32'h0, 2'b10, 0, 0, 0, 4'h0);
    do_req(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 2'b10, 0, 0, 0, 4'h0);
    do_req(1'b1, 3'b001, 32'h2001, 32'h55, 32'h0, 2'b01, 0, 0, 0, 4'h0);
    do_req(1'b0, 3'b101, 32'h45, 32'h0, 32'h0, 2'b01, 0, 0, 0, 4'h0);
  endtask

  task automatic test_timeout();
    mem_b[14'h41] = 8'hBE;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 2'b00, 4, 1, 0, 4'b0111);
    model_en = 1'b0;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 2'b11, T + 1, 1, 0, 4'b0111);
    model_en = 1'b1;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 2'b00, 4, 1, 0, 4'b0111);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    for (int i = 0; i < 16; i++) mem_b[14'h100 + 14'(i)] = 8'(i * 7 + 3);
    for (int w = 0; w < 4; w++) begin
      exp_w = {8'(w*28 + 24), 8'(w*28 + 17), 8'(w*28 + 10), 8'(w*28 + 3)};
      do_req(1'b0, 3'b010, 32'h100 + 32'(w * 4), 32'h0, exp_w, 2'b00, 4, 1, 0, 4'b0111);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_funct3   = 3'b010;
    req_addr     = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_values");
    k = 0;
    while (mem_clk_stall === 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_release got ready=%b vld=%b exp ready=1 vld=0", req_ready, rsp_valid);
    end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 2'b00, 4, 1, 0, 4'b0111);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem_b[i] = 8'h00;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_decode_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

CPU-side initiator for the data-memory stall handshake. Accepts one load/store request from the execute/memory stage and decodes RISC-V funct3 into the memory's `sign_mask` encoding. Issues a single-cycle `memread`/`memwrite` strobe, tracks the memory's `clk_stall` rise and fall, and returns load data or a completion/error response. It sits between the pipeline's memory stage and the data memory, and drives that memory's request ports directly.

## Interface

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent waiting on `clk_stall` before a timeout error.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present; sampled only while req_ready=1.
- req_ready  out  1  unit idle and able to accept a request.
- req_is_store  in  1  1 selects store, 0 selects load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (raw rs2, unshifted).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- mem_addr  out  32  to memory `addr`.
- mem_write_data  out  32  to memory `write_data`.
- mem_memread  out  1  to memory `memread`.
- mem_memwrite  out  1  to memory `memwrite`.
- mem_sign_mask  out  4  to memory `sign_mask`.
- mem_read_data  in  32  from memory `read_data`.
- mem_clk_stall  in  1  from memory `clk_stall`.

## Operation

- FSM states: IDLE, REQ, WAIT_HI, WAIT_LO, RESP. All outputs are registered.
- **IDLE:** req_ready=1. On req_valid, latch addr, wdata, funct3 and is_store.
  - Request has an error: go to RESP with rsp_err set. No memory strobe is issued.
  - Otherwise: go to REQ.
- **funct3 decode → sign_mask:**
  - Loads: LB 000→4'b1001; LH 001→4'b1011; LW 010→4'b0111; LBU 100→4'b0001; LHU 101→4'b0011.
  - Stores: SB→4'b0001; SH→4'b0011; SW→4'b0111.
  - Any other funct3 is illegal (err 10).
- **Alignment:** a halfword with addr[0]=1 is misaligned, and a word with addr[1:0]≠0 is misaligned (err 01). If a request is both illegal and misaligned, illegal wins.
- **REQ:** mem_memread or mem_memwrite is high for exactly one cycle. mem_addr, mem_write_data and mem_sign_mask are held stable from REQ through WAIT_LO. Next state is WAIT_HI.
- **WAIT_HI:** wait for mem_clk_stall=1, then go to WAIT_LO.
- **WAIT_LO:** wait for mem_clk_stall=0. Then, for a load, register mem_read_data into rsp_rdata (store: rsp_rdata=0), and go to RESP.
- **Timeout:** a counter clears on entry to REQ and increments in each WAIT_HI/WAIT_LO cycle. Reaching TIMEOUT_CYCLES goes to RESP with err 11 and rsp_rdata=0. Its width is clog2(TIMEOUT_CYCLES+1); it never wraps.
- **RESP:** rsp_valid=1 for one cycle, then go to IDLE. rsp_rdata and rsp_err hold their values until the next response.
- **Reset values:** state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, all mem_* outputs 0, counter 0.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and the in-flight memory transaction is abandoned. Integration releases reset only while the memory has clk_stall=0.

## Timing

- Let edge 0 be the accept edge (IDLE with req_valid=1).
  - Edge 1: the memory samples the strobe and raises stall.
  - Edge 2: the unit sees stall=1.
  - Edge 3: the memory drops stall and registers read_data.
  - Edge 4: the unit sees stall=0 and captures the data.
  - rsp_valid is high in the cycle after edge 4.
- Latency is the same for loads and stores. Error responses (misaligned/illegal) have rsp_valid high in the cycle after edge 0.
- req_ready is low from edge 0 until the return to IDLE. Throughput is at most one request per 6 cycles.
- The memory strobe is never held across a memory IDLE cycle, so no duplicate transaction is generated.

## Structure

- Shared package mem_if_pkg holds:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW);
  - sign_mask encodings;
  - rsp_err codes;
  - the FSM state enum.
- One combinational sub-module, mem_req_decode: funct3 + is_store + addr[1:0] → sign_mask, illegal, misaligned. The FSM, timeout counter and output registers stay in lsu_mem_initiator.

## Test plan

- **LW:** LW addr 0x40, memory model returns 0xDEADBEEF → mem_sign_mask=0111, one-cycle memread; rsp_valid 5 cycles after accept; rsp_rdata=0xDEADBEEF; err 00.
- **LB vs LBU:** LB addr 0x41 with memory byte 0x80 → mem_sign_mask=1001, rsp_rdata=0xFFFFFF80 (from model). LBU → mask 0001, rsp_rdata=0x00000080.
- **SH:** SH addr 0x2002, wdata 0x1234 → memwrite high exactly one cycle, mask 0011, mem_addr=0x2002; rsp_valid with rdata=0, err 00.
- **Decode errors:**
  - LW addr 0x42 → no strobe; rsp_valid the cycle after accept; err 01.
  - funct3=011 load → err 10.
- **Timeout:** the model never raises clk_stall → rsp_valid with err 11 after TIMEOUT_CYCLES wait cycles; the unit then accepts a new request.
- **Reset mid-transaction:** assert rst_n=0 during WAIT_LO → all outputs return to reset values asynchronously. After release, req_ready=1 and a following LW completes normally.
